// File: rtl/mem_copy_pkg.sv
// Shared types and defaults for the block-copy engine.
package mem_copy_pkg;

    localparam int DEFAULT_AW = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-at-a-time block copy engine driving a byte-wide memory port.
// Optional fill mode (constant pattern writes) is enabled by defining MEMCPY_FILL_EN.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          CLK,
    input  logic          ResetN,
    input  logic          Start,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW:0]   Len,
`ifdef MEMCPY_FILL_EN
    input  logic          Fill,
    input  logic [7:0]    FillValue,
`endif
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] MemAddress,
    output logic          MemWriteEn,
    output logic [7:0]    MemDataOut,
    input  logic [7:0]    MemDataIn
);

    state_t        r_state;
    state_t        w_nextState;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW:0]   r_remaining;
    byte_t         r_hold;
    logic          w_accept;
    logic          w_startFill;
    logic          w_fillMode;
    byte_t         w_writeData;

`ifdef MEMCPY_FILL_EN
    logic  r_fill;
    byte_t r_fillValue;

    assign w_startFill = Fill;
    assign w_fillMode  = r_fill;
    assign w_writeData = r_fill ? r_fillValue : r_hold;
`else
    assign w_startFill = 1'b0;
    assign w_fillMode  = 1'b0;
    assign w_writeData = r_hold;
`endif

    assign w_accept = (r_state == IDLE) && Start && (Len != '0);

    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (Len == '0) begin
                        w_nextState = DONE;
                    end else if (w_startFill) begin
                        w_nextState = WRITE;
                    end else begin
                        w_nextState = READ;
                    end
                end
            end
            READ:  w_nextState = WRITE;
            WRITE: begin
                if (r_remaining > (AW+1)'(1)) begin
                    w_nextState = w_fillMode ? WRITE : READ;
                end else begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_hold      <= '0;
`ifdef MEMCPY_FILL_EN
            r_fill      <= 1'b0;
            r_fillValue <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_src       <= SrcAddr;
                r_dst       <= DstAddr;
                r_remaining <= Len;
`ifdef MEMCPY_FILL_EN
                r_fill      <= Fill;
                r_fillValue <= FillValue;
`endif
            end
            if (r_state == READ) begin
                r_hold <= MemDataIn;
            end
            if (r_state == WRITE) begin
                r_src       <= r_src + AW'(1);
                r_dst       <= r_dst + AW'(1);
                r_remaining <= r_remaining - (AW+1)'(1);
            end
        end
    end

    // Write enable is qualified by ResetN so a reset landing on a WRITE cycle commits nothing.
    always_comb begin
        Busy       = 1'b0;
        Done       = 1'b0;
        MemAddress = '0;
        MemWriteEn = 1'b0;
        MemDataOut = '0;
        case (r_state)
            READ: begin
                Busy       = 1'b1;
                MemAddress = r_src;
            end
            WRITE: begin
                Busy       = 1'b1;
                MemAddress = r_dst;
                MemWriteEn = ResetN;
                MemDataOut = w_writeData;
            end
            DONE: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural byte memory.
// Fill-mode steps are compiled in when MEMCPY_FILL_EN is defined.
module tb_mem_copy_engine;

    logic       CLK;
    logic       ResetN;
    logic       Start;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [8:0] Len;
    logic       Busy;
    logic       Done;
    logic [7:0] MemAddress;
    logic       MemWriteEn;
    logic [7:0] MemDataOut;
    logic [7:0] MemDataIn;
`ifdef MEMCPY_FILL_EN
    logic       Fill;
    logic [7:0] FillValue;
`endif

    logic       preloadEn;
    logic [7:0] preloadAddr;
    logic [7:0] preloadData;
    logic [7:0] mem  [0:255];
    logic [7:0] snap [0:255];

    int checks = 0;
    int errors = 0;

    mem_copy_engine #(.AW(8)) dut (
        .CLK        (CLK),
        .ResetN     (ResetN),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Len        (Len),
`ifdef MEMCPY_FILL_EN
        .Fill       (Fill),
        .FillValue  (FillValue),
`endif
        .Busy       (Busy),
        .Done       (Done),
        .MemAddress (MemAddress),
        .MemWriteEn (MemWriteEn),
        .MemDataOut (MemDataOut),
        .MemDataIn  (MemDataIn)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural memory: combinational read, clocked write, plus a bench-only preload port.
    always @(posedge CLK) begin
        if (preloadEn) begin
            mem[preloadAddr] <= preloadData;
        end else if (MemWriteEn) begin
            mem[MemAddress] <= MemDataOut;
        end
    end

    assign MemDataIn = mem[MemAddress];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [7:0] addr, input logic [7:0] data);
        preloadEn   = 1'b1;
        preloadAddr = addr;
        preloadData = data;
        @(negedge CLK);
        preloadEn = 1'b0;
    endtask

    task automatic takeSnapshot();
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
    endtask

    function automatic int countDiffs();
        int diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
        return diffs;
    endfunction

    // Issues one request from a negedge and watches the engine until one cycle past Done.
    task automatic applyStimulus(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                                 input bit pokeBusy, output int doneCycle, output int busyCycles,
                                 output int weCycles, output int doneCount,
                                 output int addr1, output int addr2);
        doneCycle  = -1;
        busyCycles = 0;
        weCycles   = 0;
        doneCount  = 0;
        addr1      = 0;
        addr2      = 0;
        SrcAddr = src;
        DstAddr = dst;
        Len     = len;
        Start   = 1'b1;
        for (int k = 1; k <= 2 * int'(len) + 6; k++) begin
            @(negedge CLK);
            if (k == 1) Start = 1'b0;
            if (Busy) busyCycles++;
            if (MemWriteEn) weCycles++;
            if (Done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = k;
            end
            if (k == 1) addr1 = int'(MemAddress);
            if (k == 2) addr2 = int'(MemAddress);
            if (pokeBusy && k == 3) begin
                Start   = 1'b1;
                SrcAddr = 8'h00;
                DstAddr = 8'h20;
                Len     = 9'd1;
            end
            if (pokeBusy && k == 4) Start = 1'b0;
            if (doneCycle >= 0 && k >= doneCycle + 2) break;
        end
        Start = 1'b0;
    endtask

    int doneCycle, busyCycles, weCycles, doneCount, addr1, addr2;
    int doneSeen;

    initial begin
        ResetN      = 1'b0;
        Start       = 1'b0;
        SrcAddr     = 8'h00;
        DstAddr     = 8'h00;
        Len         = 9'd0;
        preloadEn   = 1'b0;
        preloadAddr = 8'h00;
        preloadData = 8'h00;
`ifdef MEMCPY_FILL_EN
        Fill      = 1'b0;
        FillValue = 8'h00;
`endif
        repeat (2) @(negedge CLK);
        checkOutput("reset Busy", int'(Busy), 0);
        checkOutput("reset Done", int'(Done), 0);
        checkOutput("reset MemWriteEn", int'(MemWriteEn), 0);
        checkOutput("reset MemAddress", int'(MemAddress), 0);
        checkOutput("reset MemDataOut", int'(MemDataOut), 0);

        for (int i = 0; i < 256; i++) preload(8'(i), 8'h00);
        ResetN = 1'b1;
        @(negedge CLK);

        // Basic copy with a Start pulse and input changes while busy.
        preload(8'h10, 8'hA1);
        preload(8'h11, 8'hB2);
        preload(8'h12, 8'hC3);
        preload(8'h13, 8'hD4);
        applyStimulus(8'h10, 8'h80, 9'd4, 1'b1, doneCycle, busyCycles, weCycles, doneCount, addr1, addr2);
        checkOutput("basic done cycle", doneCycle, 9);
        checkOutput("basic busy cycles", busyCycles, 8);
        checkOutput("basic write cycles", weCycles, 4);
        checkOutput("basic done count", doneCount, 1);
        checkOutput("basic read addr", addr1, 'h10);
        checkOutput("basic write addr", addr2, 'h80);
        checkOutput("basic M80", int'(mem[8'h80]), 'hA1);
        checkOutput("basic M81", int'(mem[8'h81]), 'hB2);
        checkOutput("basic M82", int'(mem[8'h82]), 'hC3);
        checkOutput("basic M83", int'(mem[8'h83]), 'hD4);
        checkOutput("busy poke M20 untouched", int'(mem[8'h20]), 0);
        checkOutput("idle after basic Busy", int'(Busy), 0);

        // Zero length: immediate Done, no writes.
        takeSnapshot();
        applyStimulus(8'h10, 8'h30, 9'd0, 1'b0, doneCycle, busyCycles, weCycles, doneCount, addr1, addr2);
        checkOutput("len0 done cycle", doneCycle, 1);
        checkOutput("len0 write cycles", weCycles, 0);
        checkOutput("len0 busy cycles", busyCycles, 0);
        checkOutput("len0 memory diffs", countDiffs(), 0);

        // Destination pointer wraps from 0xFF to 0x00.
        preload(8'h00, 8'h11);
        preload(8'h01, 8'h22);
        preload(8'h02, 8'h33);
        applyStimulus(8'h00, 8'hFE, 9'd3, 1'b0, doneCycle, busyCycles, weCycles, doneCount, addr1, addr2);
        checkOutput("wrap done cycle", doneCycle, 7);
        checkOutput("wrap MFE", int'(mem[8'hFE]), 'h11);
        checkOutput("wrap MFF", int'(mem[8'hFF]), 'h22);
        checkOutput("wrap M00", int'(mem[8'h00]), 'h33);

        // Full-depth self copy exercises the 9-bit length counter.
        takeSnapshot();
        applyStimulus(8'h00, 8'h00, 9'h100, 1'b0, doneCycle, busyCycles, weCycles, doneCount, addr1, addr2);
        checkOutput("full done cycle", doneCycle, 513);
        checkOutput("full write cycles", weCycles, 256);
        checkOutput("full memory diffs", countDiffs(), 0);

        // Reset during the second byte's WRITE cycle.
        preload(8'h50, 8'h01);
        preload(8'h51, 8'h02);
        preload(8'h52, 8'h03);
        preload(8'h53, 8'h04);
        SrcAddr = 8'h50;
        DstAddr = 8'h90;
        Len     = 9'd4;
        Start   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            if (k == 1) Start = 1'b0;
        end
        checkOutput("abort in WRITE WE", int'(MemWriteEn), 1);
        checkOutput("abort in WRITE addr", int'(MemAddress), 'h91);
        ResetN = 1'b0;
        @(negedge CLK);
        checkOutput("abort Busy", int'(Busy), 0);
        checkOutput("abort Done", int'(Done), 0);
        checkOutput("abort MemWriteEn", int'(MemWriteEn), 0);
        checkOutput("abort MemAddress", int'(MemAddress), 0);
        checkOutput("abort MemDataOut", int'(MemDataOut), 0);
        ResetN   = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (Done || Busy) doneSeen++;
        end
        checkOutput("abort no activity after", doneSeen, 0);
        checkOutput("abort M90 written", int'(mem[8'h90]), 'h01);
        checkOutput("abort M91 not written", int'(mem[8'h91]), 0);

`ifdef MEMCPY_FILL_EN
        // Fill mode: constant pattern, no reads.
        Fill      = 1'b1;
        FillValue = 8'h5A;
        applyStimulus(8'h10, 8'h40, 9'd3, 1'b0, doneCycle, busyCycles, weCycles, doneCount, addr1, addr2);
        Fill      = 1'b0;
        FillValue = 8'h00;
        checkOutput("fill done cycle", doneCycle, 4);
        checkOutput("fill write cycles", weCycles, 3);
        checkOutput("fill first addr", addr1, 'h40);
        checkOutput("fill M40", int'(mem[8'h40]), 'h5A);
        checkOutput("fill M41", int'(mem[8'h41]), 'h5A);
        checkOutput("fill M42", int'(mem[8'h42]), 'h5A);
        checkOutput("fill M43 untouched", int'(mem[8'h43]), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Block-transfer engine placed directly upstream of the byte-wide data memory; it drives the memory's address, write-enable and write-data pins.
- While Busy, it owns the memory port; top-level muxing gives it priority over the core's load/store path.
- It copies Len bytes from SrcAddr.. to DstAddr.., one byte per read/write pair, using the memory's combinational read and clocked write.

Parameters:
- AW, 8, address width; memory depth is 2**AW bytes.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- ResetN  in  1  synchronous active-low reset.
- Start  in  1  request; sampled only in IDLE.
- SrcAddr  in  AW  first source byte address; latched on accepted Start.
- DstAddr  in  AW  first destination byte address; latched on accepted Start.
- Len  in  AW+1  byte count, 0..2**AW; latched on accepted Start.
- Busy  out  1  high in READ and WRITE; selects this block onto the memory port.
- Done  out  1  one-cycle completion pulse.
- MemAddress  out  AW  to memory address input.
- MemWriteEn  out  1  to memory write enable.
- MemDataOut  out  8  to memory write-data input.
- MemDataIn  in  8  from memory combinational read data.

Behaviour:
- Reset: synchronous. ResetN low at a posedge forces the following:
  - state IDLE; all pointers, counter and hold register = 0.
  - Busy=0, Done=0, MemWriteEn=0, MemAddress=0, MemDataOut=0.
- FSM states: IDLE, READ, WRITE, DONE. Outputs are decoded from registered state, so there are no combinational paths from Start.
- IDLE:
  - Start=1 and Len!=0: latch src/dst/len, go to READ.
  - Start=1 and Len=0: go to DONE; no memory access.
  - Otherwise stay in IDLE.
- READ: MemAddress=src pointer, MemWriteEn=0. At the edge, capture MemDataIn into the hold register and go to WRITE.
- WRITE:
  - MemAddress=dst pointer, MemDataOut=hold, MemWriteEn=1.
  - At the edge: src+1, dst+1, remaining−1.
  - Go to READ if remaining (before decrement) >1, else DONE.
- DONE: Done=1, Busy=0 for exactly one cycle, then IDLE. Start is ignored in DONE; a new request is accepted from the next IDLE cycle.
- Latency: Len=N>0 gives Done in cycle 2N+1 after the accepting edge. Len=0 gives Done 1 cycle after.
- Start while not IDLE: ignored, no queuing. Input changes after acceptance have no effect.
- Address wrap: pointers increment modulo 2**AW. With AW=8, dst 0xFF is followed by 0x00.
- Len=2**AW: the full memory is copied; the counter is AW+1 bits wide.
- Overlap: copy is strictly forward, ascending addresses. If dst>src and the regions overlap, source bytes are overwritten before they are read; this is defined behaviour and not an error.
- Idle outputs: MemWriteEn=0, MemAddress=0, MemDataOut=0.
- Reset mid-transfer: abort at that edge. Bytes already written stay written, no further writes occur, and no Done pulse is issued.

Optional Feature:
- Macro: MEMCPY_FILL_EN.
- Defined:
  - Adds ports Fill (in, 1) and FillValue (in, 8), both latched on accepted Start.
  - Fill=1 skips READ: the engine stays in WRITE for N consecutive cycles, writing FillValue to dst..dst+N−1, then goes to DONE. Done arrives N+1 cycles after acceptance.
  - SrcAddr is ignored in fill mode.
- Undefined: the ports are absent and only copy mode exists.

Decomposition:
- Package mem_copy_pkg holds:
  - the state enum typedef (IDLE, READ, WRITE, DONE);
  - the default AW constant;
  - the byte_t typedef (8-bit).
- No sub-module: the FSM, pointers and counter stay in one module. The top-level port mux is not part of this block.

Test Plan:
- Copy, basic: preload M[0x10..0x13]=A1,B2,C3,D4; Start with Src=0x10, Dst=0x80, Len=4.
  - Expect M[0x80..0x83]=A1,B2,C3,D4.
  - Expect Done pulse in cycle 9 after acceptance and Busy high for 8 cycles.
- Len=0 with Start: Done 1 cycle later, MemWriteEn never asserted, memory unchanged.
- Address wrap: Src=0x00, Dst=0xFE, Len=3 with M[0..2]=11,22,33.
  - Expect M[0xFE]=11, M[0xFF]=22, M[0x00]=33 (M[0x00] is read before it is overwritten).
- Reset and Start while busy:
  - Pulse Start again mid-transfer: no effect on the transfer.
  - Assert ResetN=0 in WRITE of byte 2 of Len=4: only byte 1 is written, no Done, outputs return to 0 at that edge.
- Fill mode (MEMCPY_FILL_EN defined): Fill=1, FillValue=5A, Dst=0x40, Len=3.
  - Expect M[0x40..0x42]=5A and Done 4 cycles after acceptance.
